// File: rtl/matx_text_writer_if.sv
// Bundle for the matrix text writer: control, value stream in, RAM byte-write out.
interface matx_text_writer_if #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned CNT_W  = 8
) ();
   logic              start;
   logic [CNT_W-1:0]  count;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   length;

   modport master (
      output start, count, in_data, in_valid,
      input  in_ready, ram_we, ram_addr, ram_wdata, busy, done, error, length
   );

   modport slave (
      input  start, count, in_data, in_valid,
      output in_ready, ram_we, ram_addr, ram_wdata, busy, done, error, length
   );
endinterface

// File: rtl/matx_text_writer.sv
// Writes a "MATX_TAG" text image into a byte RAM: header, one hex line per value,
// and a terminating blank line.
module matx_text_writer #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned CNT_W  = 8
) (
   input logic             clk,
   input logic             reset_n,
   matx_text_writer_if.slave wr_if
);

   localparam int unsigned MaxCount = ((1 << ADDR_W) - 12) / 4;
   localparam int unsigned LenW     = ADDR_W + 1;

   typedef enum logic [3:0] {
      StIdle, StTag, StWait, StHi, StLo, StCr, StLf, StEndCr, StEndLf, StFin
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        tag_idx_q, tag_idx_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  val_cnt_q, val_cnt_d;
   logic [7:0]        data_q, data_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]        ram_wdata_q, ram_wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [LenW-1:0]   length_q, length_d;
   logic              in_ready;
   logic              addr_clr;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic [7:0] tag_byte(input logic [3:0] idx);
      case (idx)
         4'd0:    return 8'h4D; // M
         4'd1:    return 8'h41; // A
         4'd2:    return 8'h54; // T
         4'd3:    return 8'h58; // X
         4'd4:    return 8'h5F; // _
         4'd5:    return 8'h54; // T
         4'd6:    return 8'h41; // A
         4'd7:    return 8'h47; // G
         4'd8:    return 8'h0D;
         default: return 8'h0A;
      endcase
   endfunction

   always_comb begin
      state_d   = state_q;
      tag_idx_d = tag_idx_q;
      count_d   = count_q;
      val_cnt_d = val_cnt_q;
      data_d    = data_q;
      error_d   = 1'b0;
      in_ready  = 1'b0;
      addr_clr  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (wr_if.start) begin
               if (32'(wr_if.count) <= MaxCount) begin
                  count_d   = wr_if.count;
                  val_cnt_d = '0;
                  tag_idx_d = '0;
                  addr_clr  = 1'b1;
                  state_d   = StTag;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         StTag: begin
            tag_idx_d = tag_idx_q + 4'd1;
            if (tag_idx_q == 4'd9) state_d = StWait;
         end
         StWait: begin
            if (val_cnt_q == count_q) begin
               state_d = StEndCr;
            end else begin
               in_ready = 1'b1;
               if (wr_if.in_valid) begin
                  data_d  = wr_if.in_data;
                  state_d = StHi;
               end
            end
         end
         StHi:    state_d = StLo;
         StLo:    state_d = StCr;
         StCr:    state_d = StLf;
         StLf: begin
            val_cnt_d = val_cnt_q + 1'b1;
            state_d   = StWait;
         end
         StEndCr: state_d = StEndLf;
         StEndLf: state_d = StFin;
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Write outputs are decoded from the next state so they are registered yet
   // line up with the cycle in which that state is active.
   always_comb begin
      ram_we_d    = 1'b1;
      ram_wdata_d = ram_wdata_q;
      unique case (state_d)
         StTag:            ram_wdata_d = tag_byte(tag_idx_d);
         StHi:             ram_wdata_d = hex_char(data_d[7:4]);
         StLo:             ram_wdata_d = hex_char(data_d[3:0]);
         StCr, StEndCr:    ram_wdata_d = 8'h0D;
         StLf, StEndLf:    ram_wdata_d = 8'h0A;
         default:          ram_we_d    = 1'b0;
      endcase
      if (addr_clr)      ram_addr_d = '0;
      else if (ram_we_q) ram_addr_d = ram_addr_q + 1'b1;
      else               ram_addr_d = ram_addr_q;
      busy_d   = (state_d != StIdle) && (state_d != StFin);
      done_d   = (state_d == StFin);
      length_d = (state_d == StFin) ? (LenW'(12) + (LenW'(count_q) << 2)) : length_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         tag_idx_q   <= '0;
         count_q     <= '0;
         val_cnt_q   <= '0;
         data_q      <= '0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         length_q    <= '0;
      end else begin
         state_q     <= state_d;
         tag_idx_q   <= tag_idx_d;
         count_q     <= count_d;
         val_cnt_q   <= val_cnt_d;
         data_q      <= data_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         length_q    <= length_d;
      end
   end

   assign wr_if.in_ready  = in_ready;
   assign wr_if.ram_we    = ram_we_q;
   assign wr_if.ram_addr  = ram_addr_q;
   assign wr_if.ram_wdata = ram_wdata_q;
   assign wr_if.busy      = busy_q;
   assign wr_if.done      = done_q;
   assign wr_if.error     = error_q;
   assign wr_if.length    = length_q;

endmodule

// File: tb/tb_matx_text_writer.sv
// Scoreboard bench for matx_text_writer: expected RAM writes and lengths are queued
// by the stimulus side and consumed by a negedge monitor.
module tb_matx_text_writer;
   localparam int unsigned ADDR_W = 9;
   localparam int unsigned CNT_W  = 8;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   matx_text_writer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   matx_text_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_if   (bus)
   );

   wr_t        exp_q[$];
   int         exp_len_q[$];
   logic [7:0] vals[$];
   int   tests = 0, fails = 0;
   int   cyc = 0, start_cyc = 0, done_cyc = 0;
   int   done_cnt = 0, err_cnt = 0;
   int   idle_cyc = 0, idle_we = 0;
   bit   rdy_seen = 1'b0;
   wr_t  mon_w;
   string hexs = "0123456789ABCDEF";
   string hdr  = "MATX_TAG";
   logic [7:0] v32 [32] = '{8'hE1, 8'h6B, 8'hD7, 8'h1D, 8'hB6, 8'h0C, 8'h55, 8'h2D,
                            8'h1E, 8'hE8, 8'h80, 8'h27, 8'hA6, 8'h34, 8'hDB, 8'hB7,
                            8'hB9, 8'h0A, 8'h8E, 8'h98, 8'h73, 8'h99, 8'hB0, 8'hF8,
                            8'h38, 8'h76, 8'h0B, 8'hA0, 8'h6E, 8'hBC, 8'h02, 8'hD3};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every write and every done is matched against the scoreboard.
   always @(negedge clk) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      if (bus.in_ready && !bus.in_valid) begin
         idle_cyc++;
         if (bus.ram_we) idle_we++;
      end
      if (bus.error) err_cnt++;
      if (bus.ram_we) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                     bus.ram_addr, bus.ram_wdata);
         end else begin
            mon_w = exp_q.pop_front();
            check("wr_addr", 32'(bus.ram_addr), 32'(mon_w.addr));
            check("wr_data", 32'(bus.ram_wdata), 32'(mon_w.data));
         end
      end
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
         if (exp_len_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: length %0d, no file expected", bus.length);
         end else begin
            check("length", 32'(bus.length), 32'(exp_len_q.pop_front()));
         end
      end
   end

   function automatic void push_byte(input int a, input int d);
      wr_t w;
      w.addr = ADDR_W'(a);
      w.data = 8'(d);
      exp_q.push_back(w);
   endfunction

   function automatic void push_header();
      for (int i = 0; i < 8; i++) push_byte(i, int'(hdr[i]));
      push_byte(8, 'h0D);
      push_byte(9, 'h0A);
   endfunction

   function automatic void push_value(input int idx, input logic [7:0] v);
      push_byte(10 + 4 * idx, int'(hexs[int'(v[7:4])]));
      push_byte(11 + 4 * idx, int'(hexs[int'(v[3:0])]));
      push_byte(12 + 4 * idx, 'h0D);
      push_byte(13 + 4 * idx, 'h0A);
   endfunction

   function automatic void push_file(input int n);
      push_header();
      for (int i = 0; i < n; i++) push_value(i, vals[i]);
      push_byte(10 + 4 * n, 'h0D);
      push_byte(11 + 4 * n, 'h0A);
      exp_len_q.push_back(12 + 4 * n);
   endfunction

   task automatic do_start(input int n);
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.count = CNT_W'(n);
      @(posedge clk);
      #1;
      start_cyc = cyc;
      bus.start = 1'b0;
   endtask

   task automatic send_value(input logic [7:0] v, input int gap, output bit ok);
      bit hs;
      ok = 1'b0;
      if (gap > 0) begin
         bus.in_valid = 1'b0;
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(negedge clk);
         hs = bus.in_ready;
         @(posedge clk);
         #1;
         if (hs) ok = 1'b1;
      end
      if (!ok) check("handshake_timeout", 0, 1);
   endtask

   task automatic wait_done(input int base);
      for (int k = 0; k < 600 && done_cnt == base; k++) @(posedge clk);
      #1;
      check("done_seen", done_cnt - base, 1);
   endtask

   initial begin
      bit ok;
      int base, ebase;
      bus.start    = 1'b0;
      bus.count    = '0;
      bus.in_data  = '0;
      bus.in_valid = 1'b0;

      // Reset state
      #3;
      check("rst_in_ready", 32'(bus.in_ready), 0);
      check("rst_ram_we", 32'(bus.ram_we), 0);
      check("rst_ram_addr", 32'(bus.ram_addr), 0);
      check("rst_ram_wdata", 32'(bus.ram_wdata), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_error", 32'(bus.error), 0);
      check("rst_length", 32'(bus.length), 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // 32 values, in_valid held high
      foreach (v32[i]) vals.push_back(v32[i]);
      push_file(32);
      base = done_cnt;
      do_start(32);
      check("busy_after_start", 32'(bus.busy), 1);
      for (int i = 0; i < 32; i++) send_value(vals[i], 0, ok);
      wait_done(base);
      check("latency_32", done_cyc - start_cyc, 173);
      check("drained_32", exp_q.size(), 0);
      check("busy_after_done", 32'(bus.busy), 0);

      // count = 0
      bus.in_valid = 1'b0;
      vals.delete();
      push_file(0);
      @(posedge clk);
      #1 rdy_seen = 1'b0;
      base = done_cnt;
      do_start(0);
      wait_done(base);
      check("latency_0", done_cyc - start_cyc, 13);
      check("in_ready_never", 32'(rdy_seen), 0);
      check("drained_0", exp_q.size(), 0);

      // count = 3 with in_valid gaps
      vals = {8'h00, 8'h9F, 8'hFA};
      push_file(3);
      base = done_cnt;
      do_start(3);
      idle_cyc = 0;
      idle_we  = 0;
      for (int i = 0; i < 3; i++) send_value(vals[i], 8, ok);
      wait_done(base);
      check("gap_idle_cycles", idle_cyc, 8);
      check("gap_no_we", idle_we, 0);
      check("latency_gap", done_cyc - start_cyc, 36);
      check("drained_gap", exp_q.size(), 0);

      // start while busy is ignored; oversize start errors
      bus.in_valid = 1'b0;
      vals = {8'h5A, 8'hC3};
      push_file(2);
      base  = done_cnt;
      ebase = err_cnt;
      do_start(2);
      bus.start = 1'b1;
      bus.count = CNT_W'(5);
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int i = 0; i < 2; i++) send_value(vals[i], 0, ok);
      wait_done(base);
      repeat (20) @(posedge clk);
      #1;
      check("busy_start_ignored", done_cnt - base, 1);
      check("no_err_on_busy_start", err_cnt - ebase, 0);
      check("drained_busy", exp_q.size(), 0);
      bus.in_valid = 1'b0;
      do_start(126);
      check("err_busy_low", 32'(bus.busy), 0);
      check("err_pulse_now", 32'(bus.error), 1);
      repeat (15) @(posedge clk);
      #1;
      check("err_once", err_cnt - ebase, 1);
      check("err_no_done", done_cnt - base, 1);

      // Reset during HI of the fifth value
      vals = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      push_header();
      for (int i = 0; i < 4; i++) push_value(i, vals[i]);
      do_start(8);
      for (int i = 0; i < 5; i++) send_value(vals[i], 0, ok);
      reset_n = 1'b0;
      #1;
      check("abort_we", 32'(bus.ram_we), 0);
      check("abort_busy", 32'(bus.busy), 0);
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      check("abort_drained", exp_q.size(), 0);
      check("abort_addr", 32'(bus.ram_addr), 0);
      vals = {8'h4C};
      push_file(1);
      base = done_cnt;
      do_start(1);
      send_value(8'h4C, 0, ok);
      wait_done(base);
      check("drained_after_abort", exp_q.size(), 0);
      check("len_q_empty", exp_len_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/matx_text_writer.md
Name: matx_text_writer

Overview:
- Formatter that produces a matrix text file image in a byte-wide RAM, for the SD/UART data path.
- Takes a stream of binary byte values and writes the header line "MATX_TAG" CR LF.
- Each value is written as two uppercase ASCII hex characters followed by CR LF.
- A final blank line (CR LF) terminates the file. The resulting image is the same one the matrix text parser consumes, so parser and writer can be looped back.

Parameters:
ADDR_W, 9, RAM byte-address width (RAM depth 2^ADDR_W = 512)
CNT_W, 8, width of the value-count input

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begin a file, sampled only in IDLE
count  input  CNT_W  number of values to write, latched on accepted start
in_data  input  8  binary value to format
in_valid  input  1  in_data valid
in_ready  output  1  writer will accept in_data this cycle
ram_we  output  1  RAM write enable, one byte per cycle
ram_addr  output  ADDR_W  RAM write address
ram_wdata  output  8  RAM write data (ASCII)
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when the last byte has been written
error  output  1  one-cycle pulse when start is rejected for overflow
length  output  ADDR_W+1  total bytes written in the last completed file; holds until the next done

Behaviour:
- Reset values: in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0, done=0, error=0, length=0. FSM goes to IDLE.
- Reset asserted mid-operation: abort immediately. No further writes occur. Bytes already in the RAM are left untouched.
- FSM states and transitions:
  - IDLE -> TAG -> WAIT -> HI -> LO -> CR -> LF, then back to WAIT or on to END_CR.
  - END_CR -> END_LF -> FIN -> IDLE.
- IDLE:
  - On start with count <= (2^ADDR_W - 12)/4 (125 at defaults): latch count, clear the address counter and value counter, set busy, go to TAG.
  - On start with count above that limit: pulse error for 1 cycle, stay IDLE, no writes.
  - start while busy is ignored.
- TAG: 10 consecutive cycles with ram_we=1 write "M","A","T","X","_","T","A","G",0x0D,0x0A to addresses 0..9.
- WAIT:
  - If the value counter equals count, go to END_CR.
  - Otherwise in_ready=1. A transfer happens when in_valid && in_ready. On a transfer, latch in_data and go to HI. Otherwise stay.
  - in_ready is 0 in every other state.
  - A gap in in_valid inserts idle cycles with ram_we=0.
- HI / LO / CR / LF write one byte each:
  - HI: hex char of bits [7:4].
  - LO: hex char of bits [3:0].
  - CR: 0x0D.
  - LF: 0x0A.
  - Hex map: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase only).
  - After LF, increment the value counter and return to WAIT.
- END_CR / END_LF: write 0x0D then 0x0A.
- FIN: ram_we=0, pulse done, clear busy, set length = 12 + 4*count, return to IDLE.
- Address: ram_addr increments by 1 after every write cycle. It never wraps, because the overflow check guarantees the last address is at most 2^ADDR_W-1.
- Write timing: ram_we/ram_addr/ram_wdata are registered. The byte for a state is presented in the cycle that state is active.
- Latency: with in_valid held high, count=N takes 10 + 5N + 2 + 1 cycles from start to done (WAIT costs one cycle per value).
- count=0: file is "MATX_TAG" CRLF CRLF, length=12.

Test Plan:
- Load 32 values E1,6B,D7,1D,B6,0C,55,2D,1E,E8,80,27,A6,34,DB,B7,B9,0A,8E,98,73,99,B0,F8,38,76,0B,A0,6E,BC,02,D3, count=32, in_valid always high -> RAM[0..139] equals the header, "E1"CRLF ... "D3"CRLF, then CRLF at 138/139; length=140; done after 10+160+3=173 cycles.
- count=0 -> RAM[0..11] = "MATX_TAG",0D,0A,0D,0A; length=12; in_ready never asserted.
- count=3 (values 00,9F,FA) with in_valid dropped for 4 cycles before each value -> RAM bytes "00","9F","FA" each followed by CRLF at 10..21; no ram_we during the gaps; length=24.
- start pulsed again while busy, then start with count=126 after completion -> second start ignored, no extra writes; the count=126 start produces an error pulse, no ram_we, busy stays 0.
- Assert reset_n=0 while in HI for the 5th value -> ram_we=0 and busy=0 immediately; after release, IDLE; a new start with count=1 (value 4C) writes from address 0 and gives length=16.
